// File: rtl/sequenciador_programa.sv
// Program sequencer for processador_multiciclo.
// Holds a small program memory, issues each 9-bit instruction on DIN with a
// one-cycle Run pulse, follows mvi with its immediate word, waits for Done
// and stops on HALT_WORD, on address wrap or on a watchdog timeout.
module sequenciador_programa #(
    parameter int          ADDR_WIDTH = 5,
    parameter int          TIMEOUT    = 16,
    parameter logic [15:0] HALT_WORD  = 16'hFFFF
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Start,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [15:0]           prog_data,
    input  logic                  Done,
    output logic [15:0]           DIN,
    output logic                  Run,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  Busy,
    output logic                  Finished,
    output logic                  Error
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [7:0]            WD_LAST   = 8'(TIMEOUT - 1);
    localparam logic [2:0]            OP_MVI    = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_FINISHED,
        S_ERROR
    } state_t;

    state_t                  state, state_nxt;
    logic [15:0]             mem [DEPTH];
    logic [15:0]             din_nxt;
    logic                    run_nxt;
    logic [ADDR_WIDTH-1:0]   pc_nxt;
    logic [7:0]              wd, wd_nxt;
    logic                    wrap, wrap_nxt;
    logic [ADDR_WIDTH-1:0]   pc_plus1, pc_plus2;
    logic                    is_mvi;

    // The instruction being issued is still on DIN during ISSUE, so its
    // opcode decides whether an immediate follows.
    assign pc_plus1 = PC + 1'b1;
    assign pc_plus2 = PC + ADDR_WIDTH'(2);
    assign is_mvi   = (DIN[8:6] == OP_MVI);

    assign Busy     = (state == S_ISSUE) || (state == S_WAIT_DONE);
    assign Finished = (state == S_FINISHED);
    assign Error    = (state == S_ERROR);

    // Program memory write port, locked out while a program is running.
    always_ff @(posedge Clock) begin
        if (prog_we && !Busy) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // State, output and bookkeeping registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_IDLE;
            DIN   <= '0;
            Run   <= 1'b0;
            PC    <= '0;
            wd    <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            DIN   <= din_nxt;
            Run   <= run_nxt;
            PC    <= pc_nxt;
            wd    <= wd_nxt;
            wrap  <= wrap_nxt;
        end
    end

    // Next-state logic: fetch, issue, immediate hand-off and termination.
    always_comb begin
        state_nxt = state;
        din_nxt   = DIN;
        run_nxt   = 1'b0;
        pc_nxt    = PC;
        wd_nxt    = wd;
        wrap_nxt  = wrap;
        case (state)
            S_IDLE, S_FINISHED, S_ERROR: begin
                if (Start) begin
                    wrap_nxt = 1'b0;
                    if (mem[ADDR_ZERO] == HALT_WORD) begin
                        state_nxt = S_FINISHED;
                    end else begin
                        pc_nxt    = '0;
                        din_nxt   = mem[ADDR_ZERO];
                        run_nxt   = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wd_nxt = '0;
                if (is_mvi) begin
                    // An mvi in the last word has no immediate to follow it.
                    if (PC == LAST_ADDR) begin
                        state_nxt = S_ERROR;
                    end else begin
                        din_nxt   = mem[pc_plus1];
                        pc_nxt    = pc_plus2;
                        wrap_nxt  = (PC == LAST_ADDR - 1'b1);
                        state_nxt = S_WAIT_DONE;
                    end
                end else begin
                    pc_nxt    = pc_plus1;
                    wrap_nxt  = (PC == LAST_ADDR);
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                wd_nxt = wd + 1'b1;
                if (Done) begin
                    if (wrap || (mem[PC] == HALT_WORD)) begin
                        state_nxt = S_FINISHED;
                    end else begin
                        din_nxt   = mem[PC];
                        run_nxt   = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end else if (wd == WD_LAST) begin
                    state_nxt = S_ERROR;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sequenciador_programa.sv
// Testbench for sequenciador_programa: directed programs, a Done stub and a
// program-walk model predicting every issued word and the run timeline.
module tb_sequenciador_programa;

    localparam int          AW    = 5;
    localparam int          DEPTH = 32;
    localparam int          TO    = 16;
    localparam logic [15:0] HALT  = 16'hFFFF;

    logic          Clock = 1'b0;
    logic          Resetn, Start, prog_we, Done;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic [15:0]   DIN;
    logic          Run, Busy, Finished, Error;
    logic [AW-1:0] PC;

    sequenciador_programa #(.ADDR_WIDTH(AW), .TIMEOUT(TO), .HALT_WORD(HALT)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .Done(Done),
        .DIN(DIN), .Run(Run), .PC(PC), .Busy(Busy), .Finished(Finished), .Error(Error)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Model state, owned by the main process.
    logic [15:0] mdl_mem [DEPTH];
    logic [15:0] exp_word [64];
    int          exp_addr [64];
    bit          exp_mvi  [64];
    logic [15:0] exp_imm  [64];
    int          exp_n, s_cyc, e_cyc, fin_pc, dly, run_id;
    bit          out_err, err_mvi, active;

    // Walk the program as the processor would see it and derive the timeline.
    function automatic void build_model();
        int pc, npc;
        logic [15:0] w;
        bit stop, mvi;
        exp_n = 0; out_err = 0; err_mvi = 0; fin_pc = 0; pc = 0;
        stop = (mdl_mem[0] == HALT);
        while (!stop) begin
            w = mdl_mem[pc];
            mvi = (w[8:6] == 3'b001);
            exp_word[exp_n] = w;
            exp_addr[exp_n] = pc;
            exp_mvi[exp_n]  = 1'b0;
            if (mvi && pc == DEPTH - 1) begin
                out_err = 1; err_mvi = 1; stop = 1;
            end else begin
                if (mvi) begin
                    exp_mvi[exp_n] = 1'b1;
                    exp_imm[exp_n] = mdl_mem[pc + 1];
                end
                npc = pc + (mvi ? 2 : 1);
                if (npc >= DEPTH) begin
                    fin_pc = npc - DEPTH; stop = 1;
                end else if (mdl_mem[npc] == HALT) begin
                    fin_pc = npc; stop = 1;
                end else begin
                    pc = npc;
                end
            end
            exp_n++;
        end
        if (dly == 0 && exp_n > 0) begin
            exp_n = 1; out_err = 1; e_cyc = s_cyc + 1 + TO;
        end else if (err_mvi) begin
            e_cyc = s_cyc + (exp_n - 1) * (dly + 1) + 1;
        end else begin
            e_cyc = s_cyc + exp_n * (dly + 1);
        end
    endfunction

    // Done stub: answers dly cycles after each Run pulse (dly = 0 never answers).
    int pend, stub_id;
    initial begin
        Done = 1'b0; pend = -1; stub_id = 0;
        forever begin
            @(negedge Clock);
            if (stub_id != run_id) begin stub_id = run_id; pend = -1; end
            Done = 1'b0;
            if (cyc == pend) Done = 1'b1;
            if (Run === 1'b1 && dly > 0) pend = cyc + dly;
        end
    end

    // Compare process: every cycle of an active run against the model.
    int          mon_id = 0;
    int          run_i, run_cnt, run_cyc0, run_cyc1, err_rise, imm_cyc;
    bit          imm_pend, mvi_pend;
    logic [15:0] imm_val;
    logic [15:0] rf [8];
    logic [2:0]  mvi_x;
    always @(negedge Clock) begin
        logic er;
        if (mon_id != run_id) begin
            mon_id = run_id; run_i = 0; run_cnt = 0; run_cyc0 = -1; run_cyc1 = -1;
            err_rise = -1; imm_pend = 0; mvi_pend = 0;
            for (int i = 0; i < 8; i++) rf[i] = '0;
        end
        if (active && cyc >= s_cyc) begin
            er = (run_i < exp_n) && (cyc == s_cyc + run_i * (dly + 1));
            chk("run_pulse", Run, er);
            if (Run === 1'b1) begin
                run_cnt++;
                if (run_cnt == 1) run_cyc0 = cyc;
                if (run_cnt == 2) run_cyc1 = cyc;
            end
            if (imm_pend && cyc == imm_cyc) begin
                chk("mvi_imm", DIN, imm_val);
                imm_pend = 0;
            end
            if (er) begin
                chk("issue_din", DIN, exp_word[run_i]);
                chk("issue_pc", PC, exp_addr[run_i]);
                if (exp_mvi[run_i]) begin
                    imm_pend = 1; imm_cyc = cyc + 1; imm_val = exp_imm[run_i];
                end
                run_i++;
            end
            chk("busy", Busy, cyc < e_cyc);
            chk("finished", Finished, (cyc >= e_cyc) && !out_err);
            chk("error", Error, (cyc >= e_cyc) && out_err);
            if (cyc == e_cyc && !out_err) chk("final_pc", PC, fin_pc);
            if (Error === 1'b1 && err_rise < 0) err_rise = cyc;
            // Tiny processor model fed from the observed instruction stream.
            if (mvi_pend) begin rf[mvi_x] = DIN; mvi_pend = 0; end
            if (Run === 1'b1) begin
                case (DIN[8:6])
                    3'b000: rf[DIN[5:3]] = rf[DIN[2:0]];
                    3'b001: begin mvi_pend = 1; mvi_x = DIN[5:3]; end
                    3'b010: rf[DIN[5:3]] = rf[DIN[5:3]] + rf[DIN[2:0]];
                    3'b011: rf[DIN[5:3]] = rf[DIN[5:3]] - rf[DIN[2:0]];
                    default: ;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic write_word(input int a, input logic [15:0] d);
        prog_addr = AW'(a); prog_data = d; prog_we = 1'b1;
        mdl_mem[a] = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic run_prog(input int d, input bit we, input int wa, input logic [15:0] wd);
        s_cyc = cyc + 1;
        dly = d;
        build_model();
        Start = 1'b1; prog_we = we; prog_addr = AW'(wa); prog_data = wd;
        run_id++;
        active = 1'b1;
        tick();
        Start = 1'b0; prog_we = 1'b0;
        if (we) mdl_mem[wa] = wd;
        while (cyc < e_cyc + 4) tick();
        active = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Resetn = 1'b0; Start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        active = 1'b0; run_id = 0; dly = 0; s_cyc = 0; e_cyc = 0; exp_n = 0;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        repeat (2) @(posedge Clock);
        #2;
        chk("rst_din", DIN, 16'h0000);
        chk("rst_run", Run, 1'b0);
        chk("rst_pc", PC, 0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_finished", Finished, 1'b0);
        chk("rst_error", Error, 1'b0);
        Resetn = 1'b1;
        tick();

        // A: mvi R0,5 ; mvi R1,3 ; add R0,R1 ; HALT
        write_word(0, 16'h0040); write_word(1, 16'h0005);
        write_word(2, 16'h0048); write_word(3, 16'h0003);
        write_word(4, 16'h0081); write_word(5, HALT);
        run_prog(2, 0, 0, 16'h0);
        chk("A_runs", run_cnt, 3);
        chk("A_pc", PC, 5);
        chk("A_finished", Finished, 1'b1);
        chk("A_r0", rf[0], 16'd8);

        // B: Done three cycles after every Run
        write_word(0, 16'h0001); write_word(1, 16'h0002); write_word(2, HALT);
        run_prog(3, 0, 0, 16'h0);
        chk("B_runs", run_cnt, 2);
        chk("B_run0_offset", run_cyc0 - s_cyc, 0);
        chk("B_run_gap", run_cyc1 - run_cyc0, 4);

        // C: Done never arrives, then a restart from ERROR
        write_word(0, 16'h0001); write_word(1, HALT);
        run_prog(0, 0, 0, 16'h0);
        chk("C_error", Error, 1'b1);
        chk("C_timeout_latency", err_rise - run_cyc0, TO + 1);
        run_prog(2, 0, 0, 16'h0);
        chk("C_restart_finished", Finished, 1'b1);
        chk("C_restart_runs", run_cnt, 1);

        // E: write while busy is dropped; reset during a Run cycle
        write_word(0, 16'h0001); write_word(1, 16'h0002); write_word(2, HALT);
        dly = 2;
        Start = 1'b1; run_id++;
        tick();
        Start = 1'b0;
        chk("E_busy_at_write", Busy, 1'b1);
        prog_addr = AW'(1); prog_data = 16'h1234; prog_we = 1'b1;
        tick();
        prog_we = 1'b0;
        tick();
        tick();
        chk("E_run_before_reset", Run, 1'b1);
        Resetn = 1'b0;
        #1;
        chk("E_async_run", Run, 1'b0);
        chk("E_async_busy", Busy, 1'b0);
        chk("E_async_din", DIN, 16'h0000);
        chk("E_async_pc", PC, 0);
        chk("E_async_finished", Finished, 1'b0);
        chk("E_async_error", Error, 1'b0);
        tick();
        Resetn = 1'b1;
        tick();
        run_prog(2, 0, 0, 16'h0);
        chk("E_mem_kept_runs", run_cnt, 2);

        // D: mvi in the last word has no immediate
        for (int i = 0; i < DEPTH - 1; i++) write_word(i, 16'h0001);
        write_word(DEPTH - 1, 16'h0040);
        run_prog(1, 0, 0, 16'h0);
        chk("D_error", Error, 1'b1);
        chk("D_runs", run_cnt, 32);

        // F: whole memory of mv, finish by wrap
        write_word(DEPTH - 1, 16'h0001);
        run_prog(1, 0, 0, 16'h0);
        chk("F_runs", run_cnt, 32);
        chk("F_pc", PC, 0);
        chk("F_finished", Finished, 1'b1);

        // G: Start with a same-cycle write of HALT to word 0 fetches the old word
        run_prog(1, 1, 0, HALT);
        chk("G_runs", run_cnt, 32);

        // H: HALT in word 0 finishes without any issue
        run_prog(1, 0, 0, 16'h0);
        chk("H_runs", run_cnt, 0);
        chk("H_finished", Finished, 1'b1);
        chk("H_busy", Busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
